// File: rtl/edge_detector_scan_ctrl_if.sv
// Result channel from the scan controller to the digital back end.
interface edge_detector_scan_ctrl_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned CH_W = $clog2(N_CH);

  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [CNT_W-1:0] res_rise_cnt;
  logic [CNT_W-1:0] res_fall_cnt;
  logic             res_sat;

  modport master (
    output res_valid,
    output res_ch,
    output res_rise_cnt,
    output res_fall_cnt,
    output res_sat,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_ch,
    input  res_rise_cnt,
    input  res_fall_cnt,
    input  res_sat,
    output res_ready
  );
endinterface

// File: rtl/edge_detector_scan_ctrl.sv
// Time-shares one edge-detector datapath among N_CH requesting channels:
// round-robin grant, settle, count edges over a fixed window, report.
module edge_detector_scan_ctrl #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned WIN_CYC    = 64,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned CH_W      = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  output logic [CH_W-1:0] ch_sel,
  output logic            det_en,
  input  logic            rising_edge,
  input  logic            falling_edge,
  output logic            busy,
  edge_detector_scan_ctrl_if.master res
);

  localparam int unsigned TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CH_W-1:0]  ptr_q;
  logic [TMR_W-1:0] tmr_q;
  logic [CNT_W-1:0] rise_q;
  logic [CNT_W-1:0] fall_q;
  logic             sat_q;
  logic             valid_q;
  logic             grant_c;
  logic [CH_W-1:0]  grant_ch_c;
  logic [CH_W-1:0]  idx_c;

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    grant_c    = 1'b0;
    grant_ch_c = '0;
    idx_c      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx_c = CH_W'((32'(ptr_q) + i) % N_CH);
      if (!grant_c && req[idx_c]) begin
        grant_c    = 1'b1;
        grant_ch_c = idx_c;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_c)         state_d = SETTLE;
      SETTLE:  if (tmr_q == '0)     state_d = MEASURE;
      MEASURE: if (tmr_q == '0)     state_d = REPORT;
      REPORT:  if (res.res_ready)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Grant bookkeeping, timers, edge counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      ch_sel  <= '0;
      tmr_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      det_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      det_en  <= (state_d == SETTLE) || (state_d == MEASURE);
      busy    <= (state_d != IDLE);
      valid_q <= (state_d == REPORT);
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            ch_sel <= grant_ch_c;
            tmr_q  <= TMR_W'(SETTLE_CYC - 1);
            rise_q <= '0;
            fall_q <= '0;
            sat_q  <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_q == '0) tmr_q <= TMR_W'(WIN_CYC - 1);
          else             tmr_q <= tmr_q - TMR_W'(1);
        end
        MEASURE: begin
          if (tmr_q != '0) tmr_q <= tmr_q - TMR_W'(1);
          if (rising_edge) begin
            if (rise_q == CNT_MAX) sat_q  <= 1'b1;
            else                   rise_q <= rise_q + CNT_W'(1);
          end
          if (falling_edge) begin
            if (fall_q == CNT_MAX) sat_q  <= 1'b1;
            else                   fall_q <= fall_q + CNT_W'(1);
          end
        end
        REPORT: begin
          if (res.res_ready)
            ptr_q <= (ch_sel == CH_W'(N_CH - 1)) ? '0 : ch_sel + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result fields come straight from the holding registers, which are frozen in REPORT.
  assign res.res_valid    = valid_q;
  assign res.res_ch       = ch_sel;
  assign res.res_rise_cnt = rise_q;
  assign res.res_fall_cnt = fall_q;
  assign res.res_sat      = sat_q;

endmodule

// File: tb/tb_edge_detector_scan_ctrl.sv
// Bench for edge_detector_scan_ctrl: two instances (8-bit and 4-bit counters)
// share all stimulus; expected results come from a transaction-level model.
module tb_edge_detector_scan_ctrl;

  localparam int unsigned N_CH = 4;
  localparam int unsigned S    = 4;
  localparam int unsigned W    = 64;
  localparam int unsigned CW_A = 8;
  localparam int unsigned CW_B = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] req;
  logic            rising_edge;
  logic            falling_edge;
  logic            res_ready;
  logic [1:0]      ch_sel_a, ch_sel_b;
  logic            det_en_a, det_en_b;
  logic            busy_a, busy_b;

  int n_cmp = 0;
  int n_mis = 0;
  int ptr_m = 0;

  always #5 clk = ~clk;

  edge_detector_scan_ctrl_if #(.N_CH(N_CH), .CNT_W(CW_A)) if_a ();
  edge_detector_scan_ctrl_if #(.N_CH(N_CH), .CNT_W(CW_B)) if_b ();

  assign if_a.res_ready = res_ready;
  assign if_b.res_ready = res_ready;

  edge_detector_scan_ctrl #(.N_CH(N_CH), .SETTLE_CYC(S), .WIN_CYC(W), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .ch_sel(ch_sel_a), .det_en(det_en_a),
    .rising_edge(rising_edge), .falling_edge(falling_edge), .busy(busy_a), .res(if_a.master)
  );

  edge_detector_scan_ctrl #(.N_CH(N_CH), .SETTLE_CYC(S), .WIN_CYC(W), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .ch_sel(ch_sel_b), .det_en(det_en_b),
    .rising_edge(rising_edge), .falling_edge(falling_edge), .busy(busy_b), .res(if_b.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N_CH-1:0] r);
    for (int i = 0; i < int'(N_CH); i++) begin
      int idx;
      idx = (ptr + i) % int'(N_CH);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int sat_cnt(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // One full grant..transfer sequence; entered and left at a falling edge.
  // mode 0 random pulses, 1 rise every cycle, 2 five rise / four fall, 3 both every cycle.
  task automatic txn(input logic [N_CH-1:0] rq, input int mode, input int stall, input bit drop_req);
    int exp_ch, nr, nf, mx_a, mx_b;
    bit r, f, sat_a, sat_b;
    exp_ch = rr_pick(ptr_m, rq);
    mx_a = (1 << CW_A) - 1;
    mx_b = (1 << CW_B) - 1;
    nr = 0;
    nf = 0;
    req = rq;
    chk("idle_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("grant_ch", 32'(ch_sel_a), 32'(exp_ch));
    chk("det_en_on", 32'(det_en_a), 32'd1);
    if (drop_req) req = '0;
    for (int j = 1; j <= int'(S + W); j++) begin
      case (mode)
        0: begin
          r = 1'($urandom_range(0, 1));
          f = 1'($urandom_range(0, 1));
        end
        1: begin r = 1'b1; f = 1'b0; end
        2: begin
          if (j <= int'(S)) begin
            r = 1'b1;
            f = 1'b1;
          end else begin
            r = (j - int'(S) <= 5);
            f = (j - int'(S) > 10) && (j - int'(S) <= 14);
          end
        end
        default: begin r = 1'b1; f = 1'b1; end
      endcase
      rising_edge  = r;
      falling_edge = f;
      if (j > int'(S)) begin
        nr += int'(r);
        nf += int'(f);
      end
      if (j == int'(S + W)) chk("valid_early", 32'(if_a.res_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
    sat_a = (nr > mx_a) || (nf > mx_a);
    sat_b = (nr > mx_b) || (nf > mx_b);
    chk("valid_a", 32'(if_a.res_valid), 32'd1);
    chk("res_ch", 32'(if_a.res_ch), 32'(exp_ch));
    chk("rise_a", 32'(if_a.res_rise_cnt), 32'(sat_cnt(nr, CW_A)));
    chk("fall_a", 32'(if_a.res_fall_cnt), 32'(sat_cnt(nf, CW_A)));
    chk("sat_a", 32'(if_a.res_sat), 32'(sat_a));
    chk("det_en_off", 32'(det_en_a), 32'd0);
    chk("busy_rep", 32'(busy_a), 32'd1);
    chk("valid_b", 32'(if_b.res_valid), 32'd1);
    chk("rise_b", 32'(if_b.res_rise_cnt), 32'(sat_cnt(nr, CW_B)));
    chk("fall_b", 32'(if_b.res_fall_cnt), 32'(sat_cnt(nf, CW_B)));
    chk("sat_b", 32'(if_b.res_sat), 32'(sat_b));
    for (int s = 0; s < stall; s++) begin
      rising_edge  = 1'($urandom_range(0, 1));
      falling_edge = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(if_a.res_valid), 32'd1);
      chk("stall_ch", 32'(if_a.res_ch), 32'(exp_ch));
      chk("stall_sel", 32'(ch_sel_a), 32'(exp_ch));
      chk("stall_rise", 32'(if_a.res_rise_cnt), 32'(sat_cnt(nr, CW_A)));
      chk("stall_fall", 32'(if_a.res_fall_cnt), 32'(sat_cnt(nf, CW_A)));
      chk("stall_sat", 32'(if_a.res_sat), 32'(sat_a));
    end
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
    res_ready    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_drop", 32'(if_a.res_valid), 32'd0);
    chk("idle_after", 32'(busy_a), 32'd0);
    ptr_m = (exp_ch + 1) % int'(N_CH);
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = '0;
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
    res_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ch_sel", 32'(ch_sel_a), 32'd0);
    chk("rst_det_en", 32'(det_en_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_valid", 32'(if_a.res_valid), 32'd0);
    chk("rst_res_ch", 32'(if_a.res_ch), 32'd0);
    chk("rst_rise", 32'(if_a.res_rise_cnt), 32'd0);
    chk("rst_fall", 32'(if_a.res_fall_cnt), 32'd0);
    chk("rst_sat", 32'(if_a.res_sat), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_noreq", 32'(busy_a), 32'd0);

    // All channels requesting: grants rotate 0,1,2,3,0.
    for (int t = 0; t < 5; t++) txn(4'b1111, (t == 0) ? 2 : 0, 0, 1'b0);
    // Single requester, fixed pulse pattern.
    txn(4'b0100, 2, 0, 1'b0);
    // Backpressure with another request pending.
    txn(4'b1001, 0, 10, 1'b0);
    // Granted request withdrawn right after the grant.
    txn(4'b0010, 0, 0, 1'b1);
    // Saturation of the narrow counter, then simultaneous rise+fall.
    txn(4'b0001, 1, 0, 1'b0);
    txn(4'b0001, 3, 2, 1'b0);

    // Reset in the middle of a measurement.
    req = 4'b1000;
    @(posedge clk);
    for (int j = 0; j < int'(S) + 10; j++) begin
      @(negedge clk);
      rising_edge  = 1'b1;
      falling_edge = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_det_en", 32'(det_en_a), 32'd0);
    chk("arst_ch_sel", 32'(ch_sel_a), 32'd0);
    chk("arst_rise", 32'(if_a.res_rise_cnt), 32'd0);
    chk("arst_valid", 32'(if_a.res_valid), 32'd0);
    chk("arst_busy_b", 32'(busy_b), 32'd0);
    chk("arst_det_en_b", 32'(det_en_b), 32'd0);
    chk("arst_ch_sel_b", 32'(ch_sel_b), 32'd0);
    req          = '0;
    rising_edge  = 1'b0;
    falling_edge = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    repeat (S + W + 4) @(negedge clk);
    chk("no_result", 32'(if_a.res_valid), 32'd0);
    chk("no_result_b", 32'(if_b.res_valid), 32'd0);
    chk("post_rst_idle", 32'(busy_a), 32'd0);
    txn(4'b0010, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
